// File: rtl/io_led_pwm_pkg.sv
// Shared register map, channel mode encoding and address helper for the
// io_led_pwm multi-channel LED driver.
package io_led_pwm_pkg;

    localparam logic [7:0] OFS_CTRL   = 8'd0;
    localparam logic [7:0] OFS_PRESC  = 8'd1;
    localparam logic [7:0] OFS_BLINK  = 8'd2;
    localparam logic [7:0] OFS_STATUS = 8'd3;
    localparam logic [7:0] OFS_CH0    = 8'd4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } led_mode_e;

    // Each channel owns a MODE/DUTY pair starting at OFS_CH0.
    function automatic logic [7:0] chan_reg_addr(input logic [7:0] base,
                                                 input int         ch,
                                                 input logic       is_duty);
        return base + OFS_CH0 + 8'(2 * ch) + {7'b0, is_duty};
    endfunction

endpackage

// File: rtl/io_led_pwm_chan.sv
// One LED channel: MODE/DUTY registers, duty compare, mode mux and the
// registered pin driver.
module io_led_pwm_chan #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_mode,
    input  logic       wr_duty,
    input  logic [7:0] wdata,
    input  logic       gen,
    input  logic [7:0] pwm_cnt,
    input  logic       phase,
    output logic [7:0] mode_rd,
    output logic [7:0] duty_rd,
    output logic       led
);
    import io_led_pwm_pkg::*;

    led_mode_e  mode;
    logic       inv;
    logic [7:0] duty;
    logic       pwm_on;
    logic       lit;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; a same-cycle read therefore sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_OFF;
            inv  <= 1'b0;
            duty <= 8'h00;
        end else begin
            if (wr_mode) begin
                mode <= led_mode_e'(wdata[1:0]);
                inv  <= wdata[2];
            end
            if (wr_duty) begin
                duty <= wdata;
            end
        end
    end

    assign pwm_on  = pwm_cnt < duty;
    assign mode_rd = {5'b0, inv, mode};
    assign duty_rd = duty;

    // NOTE: lit gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        lit = 1'b0;
        case (mode)
            MODE_OFF:   lit = 1'b0;
            MODE_ON:    lit = 1'b1;
            MODE_PWM:   lit = pwm_on;
            MODE_BLINK: lit = pwm_on && phase;
            default:    lit = 1'b0;
        endcase
    end

    // Global disable forces the unlit level, ignoring INV.
    always_ff @(posedge clk) begin
        if (rst || !gen) begin
            led <= ACTIVE_LOW;
        end else begin
            led <= (lit ^ inv) ? !ACTIVE_LOW : ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/io_led_pwm.sv
// I/O-mapped multi-channel LED driver: bus decode, global registers, shared
// prescaler / PWM / blink counters and the registered read mux.
module io_led_pwm #(
    parameter int         NUM_CH     = 2,
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter bit         ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        io_addr,
    input  logic [7:0]        io_wdata,
    input  logic              io_wr,
    input  logic              io_rd,
    output logic [7:0]        io_rdata,
    output logic [NUM_CH-1:0] led,
    output logic              frame_tick
);
    import io_led_pwm_pkg::*;

    localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + OFS_CTRL;
    localparam logic [7:0] ADDR_PRESC  = BASE_ADDR + OFS_PRESC;
    localparam logic [7:0] ADDR_BLINK  = BASE_ADDR + OFS_BLINK;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;

    logic       gen;
    logic [7:0] presc;
    logic [7:0] blink;

    logic [7:0] presc_cnt;
    logic [7:0] pwm_cnt;
    logic [7:0] blink_cnt;
    logic       phase;
    logic       tick;
    logic       frame_wrap;

    logic [7:0] mode_rd [NUM_CH];
    logic [7:0] duty_rd [NUM_CH];
    logic [7:0] rd_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            gen   <= 1'b0;
            presc <= 8'h00;
            blink <= 8'h00;
        end else if (io_wr) begin
            if (io_addr == ADDR_CTRL)  gen   <= io_wdata[0];
            if (io_addr == ADDR_PRESC) presc <= io_wdata;
            if (io_addr == ADDR_BLINK) blink <= io_wdata;
        end
    end

    // >= rather than == so lowering PRESC below the running count ticks at once.
    assign tick       = presc_cnt >= presc;
    assign frame_wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst || !gen) begin
            presc_cnt  <= 8'h00;
            pwm_cnt    <= 8'h00;
            blink_cnt  <= 8'h00;
            phase      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (tick) begin
                presc_cnt <= 8'h00;
                pwm_cnt   <= pwm_cnt + 8'd1;
            end else begin
                presc_cnt <= presc_cnt + 8'd1;
            end
            if (frame_wrap) begin
                if (blink_cnt >= blink) begin
                    blink_cnt <= 8'h00;
                    phase     <= !phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        io_led_pwm_chan #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr_mode (io_wr && (io_addr == chan_reg_addr(BASE_ADDR, ch, 1'b0))),
            .wr_duty (io_wr && (io_addr == chan_reg_addr(BASE_ADDR, ch, 1'b1))),
            .wdata   (io_wdata),
            .gen     (gen),
            .pwm_cnt (pwm_cnt),
            .phase   (phase),
            .mode_rd (mode_rd[ch]),
            .duty_rd (duty_rd[ch]),
            .led     (led[ch])
        );
    end

    always_comb begin
        rd_mux = 8'h00;
        if (io_addr == ADDR_CTRL)   rd_mux = {7'b0, gen};
        if (io_addr == ADDR_PRESC)  rd_mux = presc;
        if (io_addr == ADDR_BLINK)  rd_mux = blink;
        if (io_addr == ADDR_STATUS) rd_mux = {6'b0, gen, phase};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (io_addr == chan_reg_addr(BASE_ADDR, ch, 1'b0)) rd_mux = mode_rd[ch];
            if (io_addr == chan_reg_addr(BASE_ADDR, ch, 1'b1)) rd_mux = duty_rd[ch];
        end
    end

    // Read data is captured only on a strobe and holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= 8'h00;
        end else if (io_rd) begin
            io_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_led_pwm.sv
// Self-checking bench for io_led_pwm: directed register/PWM/blink/gating
// scenarios plus randomized channel configurations against a timing model.
module tb_io_led_pwm;

    localparam int         NUM_CH = 2;
    localparam logic [7:0] BASE   = 8'h10;
    localparam bit         AL     = 1'b1;
    localparam int         MAP    = 4 + 2 * NUM_CH;
    localparam logic       LIT    = !AL;
    localparam logic       UNLIT  = AL;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        io_addr;
    logic [7:0]        io_wdata;
    logic              io_wr;
    logic              io_rd;
    logic [7:0]        io_rdata;
    logic [NUM_CH-1:0] led;
    logic              frame_tick;

    always #5 clk = ~clk;

    io_led_pwm #(
        .NUM_CH     (NUM_CH),
        .BASE_ADDR  (BASE),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .io_rdata   (io_rdata),
        .led        (led),
        .frame_tick (frame_tick)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] shadow [MAP];
    int         lit_cnt [NUM_CH];
    int         ft_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int ofs);
        return 8'(int'(BASE) + ofs);
    endfunction

    // Expected register contents after a write, derived from the register map.
    function automatic void shadow_write(input int ofs, input logic [7:0] d);
        if (ofs < 0 || ofs >= MAP || ofs == 3) return;
        if (ofs == 0)           shadow[ofs] = {7'b0, d[0]};
        else if (ofs < 3)       shadow[ofs] = d;
        else if (ofs % 2 == 0)  shadow[ofs] = d & 8'h07;
        else                    shadow[ofs] = d;
    endfunction

    function automatic logic [7:0] exp_read(input int ofs, input logic ph);
        if (ofs < 0 || ofs >= MAP) return 8'h00;
        if (ofs == 3) return {6'b0, shadow[0][0], ph};
        return shadow[ofs];
    endfunction

    task automatic reg_write(input int ofs, input logic [7:0] d);
        io_addr  = addr_of(ofs);
        io_wdata = d;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        shadow_write(ofs, d);
    endtask

    task automatic reg_read(input int ofs, input logic ph, input string tag);
        io_addr = addr_of(ofs);
        io_rd   = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        check(tag, 32'(io_rdata), 32'(exp_read(ofs, ph)));
    endtask

    // Phase during cycle j after enabling: the blink phase flips every
    // BLINK+1 frames, a frame being 256 ticks of PRESC+1 clocks.
    function automatic logic model_phase(input int j);
        int p = int'(shadow[1]);
        int b = int'(shadow[2]);
        int f = (j / (p + 1)) / 256;
        return ((f / (b + 1)) % 2) == 1;
    endfunction

    // Pin level in cycle k after enabling; the pin shows the previous cycle.
    function automatic logic model_led(input int ch, input int k);
        int         p;
        int         j;
        int         cnt;
        logic [7:0] m;
        logic [7:0] duty;
        logic       lit;
        if (k == 0) return UNLIT;
        p    = int'(shadow[1]);
        j    = k - 1;
        cnt  = (j / (p + 1)) % 256;
        m    = shadow[4 + 2 * ch];
        duty = shadow[5 + 2 * ch];
        case (m[1:0])
            2'd0:    lit = 1'b0;
            2'd1:    lit = 1'b1;
            2'd2:    lit = cnt < int'(duty);
            default: lit = (cnt < int'(duty)) && model_phase(j);
        endcase
        if (m[2]) lit = !lit;
        return lit ? LIT : UNLIT;
    endfunction

    // Called in cycle 0 right after the GEN=1 write; polls STATUS every cycle.
    task automatic run_enabled(input int n);
        int p = int'(shadow[1]);
        for (int k = 0; k < n; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                check($sformatf("led%0d k=%0d", ch, k), 32'(led[ch]), 32'(model_led(ch, k)));
                if (led[ch] == LIT) lit_cnt[ch]++;
            end
            check($sformatf("frame_tick k=%0d", k), 32'(frame_tick),
                  32'(k > 0 && (k % (256 * (p + 1))) == 0));
            if (frame_tick) ft_cnt++;
            if (k > 0) begin
                check($sformatf("status k=%0d", k), 32'(io_rdata),
                      32'({6'b0, 1'b1, model_phase(k - 1)}));
            end
            io_addr = addr_of(3);
            io_rd   = 1'b1;
            @(negedge clk);
        end
        io_rd = 1'b0;
    endtask

    task automatic configure(input int p, input int b, input logic [7:0] m0, input logic [7:0] d0,
                             input logic [7:0] m1, input logic [7:0] d1);
        reg_write(0, 8'h00);
        reg_write(1, 8'(p));
        reg_write(2, 8'(b));
        reg_write(4, m0);
        reg_write(5, d0);
        reg_write(6, m1);
        reg_write(7, d1);
        reg_write(0, 8'h01);
        for (int ch = 0; ch < NUM_CH; ch++) lit_cnt[ch] = 0;
        ft_cnt = 0;
    endtask

    function automatic logic [7:0] rand_duty();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        io_addr  = 8'h00;
        io_wdata = 8'h00;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        for (int i = 0; i < MAP; i++) shadow[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and every register reads zero.
        check("reset_led", 32'(led), 32'({NUM_CH{UNLIT}}));
        check("reset_rdata", 32'(io_rdata), 32'h0);
        check("reset_frame_tick", 32'(frame_tick), 32'h0);
        for (int ofs = -1; ofs <= MAP; ofs++) reg_read(ofs, 1'b0, $sformatf("reset_rd ofs=%0d", ofs));

        // Register readback, masking, unmapped, STATUS write and read hold.
        reg_write(4, 8'hFF);
        reg_read(4, 1'b0, "mode0_mask");
        check("mode0_is_07", 32'(io_rdata), 32'h07);
        reg_write(7, 8'hA5);
        reg_read(7, 1'b0, "duty1_rb");
        repeat (3) @(negedge clk);
        check("rdata_hold", 32'(io_rdata), 32'hA5);
        reg_read(8'h20, 1'b0, "unmapped_20");
        reg_write(3, 8'hFF);
        reg_read(3, 1'b0, "status_ro");
        io_addr  = addr_of(5);
        io_wdata = 8'h3C;
        io_wr    = 1'b1;
        io_rd    = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
        io_rd = 1'b0;
        check("rd_wr_old", 32'(io_rdata), 32'(exp_read(5, 1'b0)));
        shadow_write(5, 8'h3C);
        reg_read(5, 1'b0, "rd_wr_new");

        // Random register traffic, including unmapped addresses.
        for (int i = 0; i < 20; i++) reg_write($urandom_range(0, MAP + 4) - 2, 8'($urandom));
        for (int ofs = -2; ofs <= MAP + 2; ofs++) reg_read(ofs, 1'b0, $sformatf("rand_rd ofs=%0d", ofs));
        reg_write(0, 8'h00);

        // PWM 64/256 over two frames; frame_tick every 256 clocks.
        configure(0, 0, 8'h02, 8'd64, 8'h00, 8'h00);
        run_enabled(513);
        check("pwm64_lit", 32'(lit_cnt[0]), 32'd128);
        check("pwm64_ticks", 32'(ft_cnt), 32'd2);

        configure(0, 0, 8'h02, 8'd0, 8'h02, 8'd255);
        run_enabled(257);
        check("duty0_lit", 32'(lit_cnt[0]), 32'd0);
        check("duty255_lit", 32'(lit_cnt[1]), 32'd255);

        configure(0, 0, 8'h01, 8'h00, 8'h05, 8'h00);
        run_enabled(20);
        check("mode_on_lit", 32'(lit_cnt[0]), 32'd19);
        check("on_inv_lit", 32'(lit_cnt[1]), 32'd0);

        // Blink: 512 clocks dark, 512 clocks of 50% PWM.
        configure(0, 1, 8'h00, 8'h00, 8'h03, 8'd128);
        run_enabled(1025);
        check("blink_lit", 32'(lit_cnt[1]), 32'd256);

        // GEN cleared mid-frame forces unlit one clock later and holds counters.
        configure(0, 0, 8'h01, 8'h00, 8'h02, 8'd128);
        run_enabled(100);
        reg_write(0, 8'h00);
        check("gate_prev", 32'(led[0]), 32'(LIT));
        @(negedge clk);
        check("gate_led", 32'(led), 32'({NUM_CH{UNLIT}}));
        reg_write(4, 8'h04);
        for (int k = 0; k < 300; k++) begin
            check("gated_led", 32'(led), 32'({NUM_CH{UNLIT}}));
            check("gated_ft", 32'(frame_tick), 32'h0);
            if (k > 0) check("gated_status", 32'(io_rdata), 32'h0);
            io_addr = addr_of(3);
            io_rd   = 1'b1;
            @(negedge clk);
        end
        io_rd = 1'b0;
        reg_read(4, 1'b0, "gated_mode_wr");
        reg_write(0, 8'h01);
        run_enabled(600);

        // Lower PRESC from 9 to 3 while presc_cnt is 7.
        configure(9, 0, 8'h02, 8'd1, 8'h02, 8'd2);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("presc_led0 k=%0d", k), 32'(led[0]),
                  32'((k >= 1 && k <= 9) ? LIT : UNLIT));
            check($sformatf("presc_led1 k=%0d", k), 32'(led[1]),
                  32'((k >= 1 && k <= 13) ? LIT : UNLIT));
            if (k == 7) begin
                io_addr  = addr_of(1);
                io_wdata = 8'd3;
                io_wr    = 1'b1;
            end
            @(negedge clk);
            io_wr = 1'b0;
        end
        shadow_write(1, 8'd3);

        // Randomized channel configurations against the model.
        for (int t = 0; t < 5; t++) begin
            configure($urandom_range(0, 2), $urandom_range(0, 1),
                      8'($urandom), rand_duty(), 8'($urandom), rand_duty());
            run_enabled(2 * 256 * (int'(shadow[1]) + 1) * (int'(shadow[2]) + 1) + 2);
        end

        // Reset while running returns everything to reset values.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MAP; i++) shadow[i] = 8'h00;
        check("rst_mid_led", 32'(led), 32'({NUM_CH{UNLIT}}));
        check("rst_mid_ft", 32'(frame_tick), 32'h0);
        check("rst_mid_rdata", 32'(io_rdata), 32'h0);
        for (int ofs = 0; ofs < MAP; ofs++) reg_read(ofs, 1'b0, $sformatf("rst_mid_rd ofs=%0d", ofs));
        check("rst_mid_led_after", 32'(led), 32'({NUM_CH{UNLIT}}));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
